video_pattern_source: RTL and testbench

Test-pattern responder at the far upstream end of the video scaling pipeline. Services chunk requests that the scaler chain pushes upstream. Pops one {row, chunk} request from the request FIFO and writes CHUNK_SIZE RGB565 pixels of a colour-bar pattern with a frame border into the response FIFO. Stands in for a framebuffer or generator so the scaler chain can be brought up and verified in isolation.

---
 rtl/video_pipeline_pkg.sv | 47 ++++
 rtl/video_pattern_pixel.sv | 49 ++++
 rtl/video_pattern_source.sv | 112 +++++++++++
 tb/tb_video_pattern_source.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pipeline_pkg.sv
// Shared definitions for the video scaling pipeline.
// Holds the active-area widths, the request word layout, the RGB565 pixel type,
// the eight colour-bar constants and the pattern-source state encoding.
package video_pipeline_pkg;

  localparam int HACTIVE_BITS       = 11;
  localparam int VACTIVE_BITS       = 11;
  localparam int DEFAULT_CHUNK_BITS = 5;
  localparam int CHUNKNUM_BITS      = HACTIVE_BITS - DEFAULT_CHUNK_BITS;
  localparam int REQUEST_BITS       = VACTIVE_BITS + CHUNKNUM_BITS;
  localparam int BITS_PER_PIXEL     = 16;

  typedef logic [BITS_PER_PIXEL-1:0] pixelT;

  localparam pixelT BAR_WHITE   = 16'hFFFF;
  localparam pixelT BAR_YELLOW  = 16'hFFE0;
  localparam pixelT BAR_CYAN    = 16'h07FF;
  localparam pixelT BAR_GREEN   = 16'h07E0;
  localparam pixelT BAR_MAGENTA = 16'hF81F;
  localparam pixelT BAR_RED     = 16'hF800;
  localparam pixelT BAR_BLUE    = 16'h001F;
  localparam pixelT BAR_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    EMIT  = 2'd2
  } patternStateT;

  // Bar colour for a 3-bit bar index; the pattern repeats every eight bars.
  function automatic pixelT barColor(input logic [2:0] index);
    pixelT color;
    color = BAR_BLACK;
    case (index)
      3'd0: color = BAR_WHITE;
      3'd1: color = BAR_YELLOW;
      3'd2: color = BAR_CYAN;
      3'd3: color = BAR_GREEN;
      3'd4: color = BAR_MAGENTA;
      3'd5: color = BAR_RED;
      3'd6: color = BAR_BLUE;
      default: color = BAR_BLACK;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational pixel generator for the test pattern.
// Maps a source (row, column) and the per-chunk captured configuration to one
// RGB565 pixel: black outside the visible area, border colour on the one-pixel
// frame, otherwise a colour bar selected by column >> barShift.
// Optional feature macro: VIDEO_PATTERN_GRID_EN adds a white 16x16 grid over the
// bars (never over the border or the black area).
// Ports:
//   row, column              pixel coordinate
//   barShift                 bar width = 1 << barShift columns
//   lastRow, lastColumn      last visible row / column
//   borderColor              frame border colour
//   pixel                    resulting RGB565 value
module video_pattern_pixel
  import video_pipeline_pkg::*;
(
  input  logic [VACTIVE_BITS-1:0] row,
  input  logic [HACTIVE_BITS-1:0] column,
  input  logic [3:0]              barShift,
  input  logic [VACTIVE_BITS-1:0] lastRow,
  input  logic [HACTIVE_BITS-1:0] lastColumn,
  input  pixelT                   borderColor,
  output pixelT                   pixel
);

  logic [2:0] barIndex;
  logic       outside;
  logic       onBorder;
  logic       onGrid;

  // Only the low three bits of the bar number matter: the bars wrap every eight.
  assign barIndex = 3'(column >> barShift);
  assign outside  = (row > lastRow) || (column > lastColumn);
  assign onBorder = (row == '0) || (row == lastRow) || (column == '0) || (column == lastColumn);

`ifdef VIDEO_PATTERN_GRID_EN
  assign onGrid = (column[3:0] == 4'd0) || (row[3:0] == 4'd0);
`else
  assign onGrid = 1'b0;
`endif

  always_comb begin
    pixel = BAR_BLACK;
    if (outside)       pixel = BAR_BLACK;
    else if (onBorder) pixel = borderColor;
    else if (onGrid)   pixel = BAR_WHITE;
    else               pixel = barColor(barIndex);
  end

endmodule

// File: rtl/video_pattern_source.sv
// Test-pattern responder at the upstream end of the scaler chain.
// Pops one {row, chunk} request, then pushes 1 << CHUNK_BITS RGB565 pixels of the
// colour-bar/border pattern for that chunk into the response FIFO.
// Optional feature macro: VIDEO_PATTERN_GRID_EN (grid overlay, see video_pattern_pixel).
// Ports:
//   scalerClock, reset (async, active-low)
//   barShift, lastRow, lastColumn, borderColor   pattern configuration, captured per chunk
//   requestFifoReadEnable/Empty/ReadData          request FIFO read side
//   responseFifoWriteEnable/Full/WriteData        response FIFO write side
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; pops as soon as the FIFO is non-empty
// LATCH | popped word now valid; capture request and configuration
// EMIT  | writing pixels of the chunk, stalling while the FIFO is full
module video_pattern_source
  import video_pipeline_pkg::*;
#(
  parameter int CHUNK_BITS = DEFAULT_CHUNK_BITS
) (
  input  logic                                           scalerClock,
  input  logic                                           reset,
  input  logic [3:0]                                     barShift,
  input  logic [VACTIVE_BITS-1:0]                        lastRow,
  input  logic [HACTIVE_BITS-1:0]                        lastColumn,
  input  logic [BITS_PER_PIXEL-1:0]                      borderColor,
  output logic                                           requestFifoReadEnable,
  input  logic                                           requestFifoEmpty,
  input  logic [VACTIVE_BITS+HACTIVE_BITS-CHUNK_BITS-1:0] requestFifoReadData,
  output logic                                           responseFifoWriteEnable,
  input  logic                                           responseFifoFull,
  output logic [BITS_PER_PIXEL-1:0]                      responseFifoWriteData
);

  localparam int chunkNumBits = HACTIVE_BITS - CHUNK_BITS;
  localparam int requestBits  = VACTIVE_BITS + chunkNumBits;
  localparam logic [CHUNK_BITS-1:0] lastPixel = '1;

  patternStateT              state;
  patternStateT              stateNext;
  logic [CHUNK_BITS-1:0]     pixelIndex;
  logic [VACTIVE_BITS-1:0]   rowQ;
  logic [chunkNumBits-1:0]   chunkQ;
  logic [3:0]                barShiftQ;
  logic [VACTIVE_BITS-1:0]   lastRowQ;
  logic [HACTIVE_BITS-1:0]   lastColumnQ;
  pixelT                     borderColorQ;
  pixelT                     pixel;

  always_ff @(posedge scalerClock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Enables are qualified with reset so nothing handshakes while it is held.
  always_comb begin
    stateNext               = state;
    requestFifoReadEnable   = 1'b0;
    responseFifoWriteEnable = 1'b0;
    case (state)
      IDLE: begin
        if (!requestFifoEmpty) begin
          requestFifoReadEnable = reset;
          stateNext             = LATCH;
        end
      end
      LATCH: stateNext = EMIT;
      EMIT: begin
        if (!responseFifoFull) begin
          responseFifoWriteEnable = reset;
          if (pixelIndex == lastPixel) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge scalerClock or negedge reset) begin
    if (!reset) begin
      pixelIndex   <= '0;
      rowQ         <= '0;
      chunkQ       <= '0;
      barShiftQ    <= '0;
      lastRowQ     <= '0;
      lastColumnQ  <= '0;
      borderColorQ <= '0;
    end else if (state == LATCH) begin
      pixelIndex   <= '0;
      rowQ         <= requestFifoReadData[requestBits-1 -: VACTIVE_BITS];
      chunkQ       <= requestFifoReadData[chunkNumBits-1:0];
      barShiftQ    <= barShift;
      lastRowQ     <= lastRow;
      lastColumnQ  <= lastColumn;
      borderColorQ <= borderColor;
    end else if (responseFifoWriteEnable) begin
      pixelIndex   <= pixelIndex + 1'b1;
    end
  end

  video_pattern_pixel pixelGen (
    .row         (rowQ),
    .column      ({chunkQ, pixelIndex}),
    .barShift    (barShiftQ),
    .lastRow     (lastRowQ),
    .lastColumn  (lastColumnQ),
    .borderColor (borderColorQ),
    .pixel       (pixel)
  );

  assign responseFifoWriteData = (state == EMIT) ? pixel : '0;

endmodule

// File: tb/tb_video_pattern_source.sv
`timescale 1ns/1ps
module tb_video_pattern_source;

  localparam int CS = 32;

  logic        scalerClock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  barShift = 4'd3;
  logic [10:0] lastRow = 11'd479;
  logic [10:0] lastColumn = 11'd639;
  logic [15:0] borderColor = 16'hF800;
  logic        requestFifoReadEnable;
  logic        requestFifoEmpty = 1'b1;
  logic [16:0] requestFifoReadData = '0;
  logic        responseFifoWriteEnable;
  logic        responseFifoFull = 1'b0;
  logic [15:0] responseFifoWriteData;

  int errors = 0;
  int checks = 0;
  int cycle = 0;

  logic [16:0] reqQ[$];
  bit          popPending = 0;
  int          popCycles[$];
  logic [15:0] wrData[$];
  int          wrCycles[$];

  video_pattern_source dut (
    .scalerClock             (scalerClock),
    .reset                   (reset),
    .barShift                (barShift),
    .lastRow                 (lastRow),
    .lastColumn              (lastColumn),
    .borderColor             (borderColor),
    .requestFifoReadEnable   (requestFifoReadEnable),
    .requestFifoEmpty        (requestFifoEmpty),
    .requestFifoReadData     (requestFifoReadData),
    .responseFifoWriteEnable (responseFifoWriteEnable),
    .responseFifoFull        (responseFifoFull),
    .responseFifoWriteData   (responseFifoWriteData)
  );

  always #5 scalerClock = ~scalerClock;
  always @(posedge scalerClock) cycle++;

  // Request FIFO model (data valid the cycle after a pop) and handshake monitor.
  // Handshakes seen here fire on the following rising edge.
  always @(negedge scalerClock) begin
    if (popPending) begin
      if (reqQ.size() > 0) requestFifoReadData = reqQ.pop_front();
      popPending = 0;
    end
    requestFifoEmpty = (reqQ.size() == 0);
    #1;
    if (requestFifoReadEnable) begin
      popPending = 1;
      popCycles.push_back(cycle + 1);
    end
    if (responseFifoWriteEnable) begin
      wrData.push_back(responseFifoWriteData);
      wrCycles.push_back(cycle + 1);
    end
  end

  // Reference: pattern rules stated directly in terms of coordinates.
  function automatic logic [15:0] refPixel(input int row, input int x, input int shift,
                                           input int lr, input int lc, input logic [15:0] border);
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    if (row > lr || x > lc) return 16'h0000;
    if (row == 0 || row == lr || x == 0 || x == lc) return border;
`ifdef VIDEO_PATTERN_GRID_EN
    if (x % 16 == 0 || row % 16 == 0) return 16'hFFFF;
`endif
    return bars[(x / (1 << shift)) % 8];
  endfunction

  task automatic clearLogs();
    popCycles.delete();
    wrData.delete();
    wrCycles.delete();
  endtask

  task automatic pushRequest(input int row, input int chunk);
    logic [16:0] word;
    word = {11'(row), 6'(chunk)};
    reqQ.push_back(word);
  endtask

  task automatic setConfig(input int shift, input int lr, input int lc, input logic [15:0] border);
    barShift    = 4'(shift);
    lastRow     = 11'(lr);
    lastColumn  = 11'(lc);
    borderColor = border;
  endtask

  // Waits for n writes; chaos toggles full randomly and scrambles config after capture.
  task automatic collect(input int n, input int budget, input bit chaos, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge scalerClock); #1;
      if (chaos) begin
        responseFifoFull = ($urandom_range(0, 3) == 0);
        if (popCycles.size() > 0 && cycle >= popCycles[0] + 1)
          setConfig($urandom_range(0, 15), $urandom_range(0, 2047), $urandom_range(0, 2047), 16'($urandom));
      end
      if (wrData.size() >= n) begin
        ok = 1;
        break;
      end
    end
    responseFifoFull = 0;
    repeat (4) @(posedge scalerClock);
    #1;
  endtask

  task automatic test_reset();
    bit ok;
    setConfig(3, 479, 639, 16'hF800);
    pushRequest(5, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge scalerClock); #1;
      responseFifoFull = ~responseFifoFull;
      barShift = 4'($urandom);
      @(negedge scalerClock); #2;
      checks++;
      if (requestFifoReadEnable !== 1'b0 || responseFifoWriteEnable !== 1'b0 || responseFifoWriteData !== 16'h0000) begin
        errors++;
        $display("FAIL reset_outputs: rd=%b wr=%b data=%h, required 0 0 0000",
                 requestFifoReadEnable, responseFifoWriteEnable, responseFifoWriteData);
      end
    end
    checks++;
    if (popCycles.size() != 0) begin
      errors++;
      $display("FAIL reset_no_pop: pops=%0d, required 0", popCycles.size());
    end
    responseFifoFull = 0;
    setConfig(3, 479, 639, 16'hF800);
    @(posedge scalerClock); #1;
    reset = 1;
    repeat (4) @(posedge scalerClock);
    #1;
    checks++;
    if (popCycles.size() != 1) begin
      errors++;
      $display("FAIL reset_release_pop: pops=%0d, required 1", popCycles.size());
    end
    collect(CS, 200, 0, ok);
    checks++;
    if (!ok || wrData.size() != CS) begin
      errors++;
      $display("FAIL reset_release_chunk: writes=%0d, required %0d", wrData.size(), CS);
    end
    clearLogs();
  endtask

  task automatic test_bars(input int row, input int chunk, input string tag);
    bit ok;
    setConfig(3, 479, 639, 16'hF800);
    @(posedge scalerClock); #1;
    pushRequest(row, chunk);
    collect(CS, 200, 0, ok);
    checks++;
    if (!ok || wrData.size() != CS || popCycles.size() != 1) begin
      errors++;
      $display("FAIL %s_count: writes=%0d pops=%0d, required %0d 1", tag, wrData.size(), popCycles.size(), CS);
    end else begin
      checks++;
      if (wrCycles[0] - popCycles[0] != 2 || wrCycles[CS-1] - wrCycles[0] != CS - 1) begin
        errors++;
        $display("FAIL %s_latency: first=%0d last-first=%0d, required 2 %0d",
                 tag, wrCycles[0] - popCycles[0], wrCycles[CS-1] - wrCycles[0], CS - 1);
      end
      for (int p = 0; p < CS; p++) begin
        logic [15:0] exp;
        exp = refPixel(row, chunk * CS + p, 3, 479, 639, 16'hF800);
        checks++;
        if (wrData[p] !== exp) begin
          errors++;
          $display("FAIL %s_pixel%0d: got %h, required %h", tag, p, wrData[p], exp);
        end
      end
    end
    clearLogs();
  endtask

  task automatic test_full_stall();
    bit ok;
    logic [15:0] exp9;
    setConfig(3, 479, 639, 16'hF800);
    exp9 = refPixel(5, 9, 3, 479, 639, 16'hF800);
    pushRequest(5, 0);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge scalerClock); #1;
      if (wrData.size() == 9) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_reach9: writes=%0d, required 9", wrData.size());
    end
    responseFifoFull = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge scalerClock); #2;
      checks++;
      if (responseFifoWriteEnable !== 1'b0 || responseFifoWriteData !== exp9) begin
        errors++;
        $display("FAIL stall_hold: wr=%b data=%h, required 0 %h", responseFifoWriteEnable, responseFifoWriteData, exp9);
      end
      if (i < 4) @(posedge scalerClock);
    end
    @(posedge scalerClock); #1;
    responseFifoFull = 0;
    collect(CS, 200, 0, ok);
    checks++;
    if (!ok || wrData.size() != CS) begin
      errors++;
      $display("FAIL stall_count: writes=%0d, required %0d", wrData.size(), CS);
    end else begin
      checks++;
      if (wrCycles[9] - wrCycles[8] != 6) begin
        errors++;
        $display("FAIL stall_gap: gap=%0d, required 6", wrCycles[9] - wrCycles[8]);
      end
      for (int p = 0; p < CS; p++) begin
        checks++;
        if (wrData[p] !== refPixel(5, p, 3, 479, 639, 16'hF800)) begin
          errors++;
          $display("FAIL stall_pixel%0d: got %h, required %h", p, wrData[p], refPixel(5, p, 3, 479, 639, 16'hF800));
        end
      end
    end
    clearLogs();
  endtask

  task automatic test_below_frame();
    bit ok;
    setConfig(3, 479, 639, 16'hF800);
    pushRequest(480, 3);
    collect(CS, 200, 0, ok);
    checks++;
    if (!ok || wrData.size() != CS) begin
      errors++;
      $display("FAIL black_count: writes=%0d, required %0d", wrData.size(), CS);
    end else begin
      for (int p = 0; p < CS; p++) begin
        checks++;
        if (wrData[p] !== 16'h0000) begin
          errors++;
          $display("FAIL black_pixel%0d: got %h, required 0000", p, wrData[p]);
        end
      end
    end
    clearLogs();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int rows[3] = '{7, 100, 479};
    int chunks[3] = '{1, 10, 19};
    setConfig(2, 479, 639, 16'h1234);
    for (int r = 0; r < 3; r++) pushRequest(rows[r], chunks[r]);
    collect(3 * CS, 400, 0, ok);
    checks++;
    if (!ok || wrData.size() != 3 * CS || popCycles.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: writes=%0d pops=%0d, required %0d 3", wrData.size(), popCycles.size(), 3 * CS);
    end else begin
      for (int r = 1; r < 3; r++) begin
        checks++;
        if (popCycles[r] - popCycles[r-1] != CS + 2) begin
          errors++;
          $display("FAIL b2b_spacing%0d: gap=%0d, required %0d", r, popCycles[r] - popCycles[r-1], CS + 2);
        end
      end
      for (int r = 0; r < 3; r++)
        for (int p = 0; p < CS; p++) begin
          logic [15:0] exp;
          exp = refPixel(rows[r], chunks[r] * CS + p, 2, 479, 639, 16'h1234);
          checks++;
          if (wrData[r * CS + p] !== exp) begin
            errors++;
            $display("FAIL b2b_req%0d_pixel%0d: got %h, required %h", r, p, wrData[r * CS + p], exp);
          end
        end
    end
    clearLogs();
  endtask

  task automatic test_reset_mid_chunk();
    bit ok;
    setConfig(3, 479, 639, 16'hF800);
    pushRequest(5, 0);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge scalerClock); #1;
      if (wrData.size() == 10) ok = 1;
    end
    reset = 0;
    #1;
    checks++;
    if (!ok || responseFifoWriteEnable !== 1'b0) begin
      errors++;
      $display("FAIL midreset_drop: reached=%0d wr=%b, required 1 0", ok, responseFifoWriteEnable);
    end
    repeat (2) @(posedge scalerClock);
    #1;
    reset = 1;
    repeat (3) @(posedge scalerClock);
    #1;
    checks++;
    if (wrData.size() != 10) begin
      errors++;
      $display("FAIL midreset_abandon: writes=%0d, required 10", wrData.size());
    end
    clearLogs();
    pushRequest(9, 2);
    collect(CS, 200, 0, ok);
    checks++;
    if (!ok || wrData.size() != CS || popCycles.size() != 1) begin
      errors++;
      $display("FAIL midreset_next_count: writes=%0d pops=%0d, required %0d 1", wrData.size(), popCycles.size(), CS);
    end else begin
      for (int p = 0; p < CS; p++) begin
        checks++;
        if (wrData[p] !== refPixel(9, 2 * CS + p, 3, 479, 639, 16'hF800)) begin
          errors++;
          $display("FAIL midreset_pixel%0d: got %h, required %h", p, wrData[p], refPixel(9, 2 * CS + p, 3, 479, 639, 16'hF800));
        end
      end
    end
    clearLogs();
  endtask

  task automatic test_random(input int n);
    bit ok;
    for (int t = 0; t < n; t++) begin
      int shift, lr, lc, row, chunk;
      logic [15:0] border;
      shift  = $urandom_range(0, 6);
      lr     = $urandom_range(16, 1200);
      lc     = $urandom_range(16, 2047);
      row    = $urandom_range(0, 1300);
      chunk  = $urandom_range(0, 63);
      border = 16'($urandom);
      setConfig(shift, lr, lc, border);
      pushRequest(row, chunk);
      collect(CS, 400, 1, ok);
      checks++;
      if (!ok || wrData.size() != CS) begin
        errors++;
        $display("FAIL rand%0d_count: writes=%0d, required %0d", t, wrData.size(), CS);
      end else begin
        for (int p = 0; p < CS; p++) begin
          logic [15:0] exp;
          exp = refPixel(row, chunk * CS + p, shift, lr, lc, border);
          checks++;
          if (wrData[p] !== exp) begin
            errors++;
            $display("FAIL rand%0d_pixel%0d: got %h, required %h (row %0d chunk %0d)", t, p, wrData[p], exp, row, chunk);
          end
        end
      end
      clearLogs();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bars(5, 0, "bars_chunk0");
    test_full_stall();
    test_bars(5, 19, "bars_chunk19");
    test_below_frame();
    test_back_to_back();
    test_reset_mid_chunk();
    test_bars(16, 0, "grid_row16");
    test_random(25);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
